// File: rtl/maxpool_reduce_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | maxpool_reduce_fifo_if                                                   |
// | Window input and tagged result output bundle for maxpool_reduce_fifo.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface maxpool_reduce_fifo_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int KERNEL_HEIGHT = 2,
    parameter int IMAGE_WIDTH   = 188,
    parameter int IMAGE_HEIGHT  = 120,
    parameter int OUT_CHANNELS  = 16
);
    localparam int c_pool_w = IMAGE_WIDTH / 2;
    localparam int c_pool_h = (IMAGE_HEIGHT + 1) / 2;
    localparam int c_chan_w = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int c_col_w  = (c_pool_w > 1) ? $clog2(c_pool_w) : 1;
    localparam int c_row_w  = (c_pool_h > 1) ? $clog2(c_pool_h) : 1;

    logic                                         win_valid;
    logic [KERNEL_HEIGHT-1:0][1:0][DATA_WIDTH-1:0] window;
    logic                                         out_valid;
    logic                                         out_ready;
    logic [DATA_WIDTH-1:0]                        out_data;
    logic [c_chan_w-1:0]                          out_chan;
    logic [c_col_w-1:0]                           out_col;
    logic [c_row_w-1:0]                           out_row;
    logic                                         out_last;
    logic                                         almost_full;
    logic                                         overflow;
    logic                                         frame_done;

    modport slave (
        input  win_valid, window, out_ready,
        output out_valid, out_data, out_chan, out_col, out_row, out_last,
               almost_full, overflow, frame_done
    );

    modport master (
        output win_valid, window, out_ready,
        input  out_valid, out_data, out_chan, out_col, out_row, out_last,
               almost_full, overflow, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/maxpool_reduce_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | maxpool_reduce_fifo                                                      |
// | 2x2 window max reduction with channel/column/row tagging and output FIFO.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module maxpool_reduce_fifo #(
    parameter int DATA_WIDTH    = 16,
    parameter int KERNEL_HEIGHT = 2,
    parameter int IMAGE_WIDTH   = 188,
    parameter int IMAGE_HEIGHT  = 120,
    parameter int OUT_CHANNELS  = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int SIGNED_CMP    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    maxpool_reduce_fifo_if.slave bus
);
    localparam int c_pool_w = IMAGE_WIDTH / 2;
    localparam int c_pool_h = (IMAGE_HEIGHT + 1) / 2;
    localparam int c_chan_w = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int c_col_w  = (c_pool_w > 1) ? $clog2(c_pool_w) : 1;
    localparam int c_row_w  = (c_pool_h > 1) ? $clog2(c_pool_h) : 1;
    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [c_chan_w-1:0]   chan;
        logic [c_col_w-1:0]    col;
        logic [c_row_w-1:0]    row;
        logic                  last;
    } entry_t;

    function automatic logic [DATA_WIDTH-1:0] f_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
        logic gt;
        if (SIGNED_CMP != 0) gt = ($signed(a) > $signed(b));
        else                 gt = (a > b);
        return gt ? a : b;
    endfunction

    logic [DATA_WIDTH-1:0] r_m [KERNEL_HEIGHT];
    logic                  r_s1_valid;
    logic                  r_s2_valid;
    entry_t                r_s2;
    logic [c_chan_w-1:0]   r_chan;
    logic [c_col_w-1:0]    r_col;
    logic [c_row_w-1:0]    r_row;
    entry_t                r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_frame_done;

    logic                  w_chan_max;
    logic                  w_col_max;
    logic                  w_row_max;
    logic                  w_full;
    logic                  w_head_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [c_cnt_w-1:0]    w_count_nxt;
    entry_t                w_head;

    assign w_chan_max   = (r_chan == c_chan_w'(OUT_CHANNELS - 1));
    assign w_col_max    = (r_col == c_col_w'(c_pool_w - 1));
    assign w_row_max    = (r_row == c_row_w'(c_pool_h - 1));
    assign w_full       = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_head_valid = (r_count != '0);
    assign w_pop        = w_head_valid && bus.out_ready;
    // At full an incoming result is kept only if the head leaves on the same edge.
    assign w_push       = r_s2_valid && (!w_full || w_pop);
    assign w_head       = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_w'(1);
            2'b01:   w_count_nxt = r_count - c_cnt_w'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Reduction pipeline: per-row max, then max across rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < KERNEL_HEIGHT; r++) r_m[r] <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2       <= '0;
        end else begin
            r_s1_valid <= bus.win_valid;
            if (bus.win_valid) begin
                for (int r = 0; r < KERNEL_HEIGHT; r++)
                    r_m[r] <= f_max(bus.window[r][0], bus.window[r][1]);
            end
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2.data <= f_max(r_m[0], r_m[1]);
                r_s2.chan <= r_chan;
                r_s2.col  <= r_col;
                r_s2.row  <= r_row;
                r_s2.last <= w_chan_max && w_col_max && w_row_max;
            end
        end
    end

    // Tags advance on every reduced window, dropped or not, so they stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chan <= '0;
            r_col  <= '0;
            r_row  <= '0;
        end else if (r_s1_valid) begin
            if (w_chan_max) begin
                r_chan <= '0;
                if (w_col_max) begin
                    r_col <= '0;
                    r_row <= w_row_max ? '0 : r_row + c_row_w'(1);
                end else begin
                    r_col <= r_col + c_col_w'(1);
                end
            end else begin
                r_chan <= r_chan + c_chan_w'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_s2;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (r_s2_valid && !w_push) r_overflow <= 1'b1;
            r_count       <= w_count_nxt;
            r_almost_full <= (w_count_nxt >= c_cnt_w'(FIFO_DEPTH - 2));
            r_frame_done  <= w_pop && w_head.last;
        end
    end

    assign bus.out_valid   = w_head_valid;
    assign bus.out_data    = w_head.data;
    assign bus.out_chan    = w_head.chan;
    assign bus.out_col     = w_head.col;
    assign bus.out_row     = w_head.row;
    assign bus.out_last    = w_head_valid && w_head.last;
    assign bus.almost_full = r_almost_full;
    assign bus.overflow    = r_overflow;
    assign bus.frame_done  = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_maxpool_reduce_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_maxpool_reduce_fifo                                                   |
// | Directed bench: small frame (2 ch, 2x2 pooled), 4-deep FIFO.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_maxpool_reduce_fifo;
    logic clk;
    logic rst;

    maxpool_reduce_fifo_if #(.DATA_WIDTH(16), .KERNEL_HEIGHT(2), .IMAGE_WIDTH(4),
                             .IMAGE_HEIGHT(3), .OUT_CHANNELS(2)) ai ();
    maxpool_reduce_fifo_if #(.DATA_WIDTH(16), .KERNEL_HEIGHT(2), .IMAGE_WIDTH(4),
                             .IMAGE_HEIGHT(3), .OUT_CHANNELS(2)) bi ();

    maxpool_reduce_fifo #(.DATA_WIDTH(16), .KERNEL_HEIGHT(2), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3),
                          .OUT_CHANNELS(2), .FIFO_DEPTH(4), .SIGNED_CMP(1))
        u_dut_s (.clk(clk), .rst(rst), .bus(ai));

    maxpool_reduce_fifo #(.DATA_WIDTH(16), .KERNEL_HEIGHT(2), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(3),
                          .OUT_CHANNELS(2), .FIFO_DEPTH(4), .SIGNED_CMP(0))
        u_dut_u (.clk(clk), .rst(rst), .bus(bi));

    assign bi.win_valid = ai.win_valid;
    assign bi.window    = ai.window;
    assign bi.out_ready = 1'b1;

    int            n_vec;
    int            n_err;
    int            fd_cnt;
    logic [19:0]   q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Popped entries and frame_done pulses, sampled mid-low-phase.
    always @(negedge clk) begin
        #3;
        if (ai.out_valid && ai.out_ready)
            q.push_back({ai.out_data, ai.out_chan, ai.out_col, ai.out_row, ai.out_last});
        if (ai.frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] base_of(input int k);
        return 16'(k * 10 - 40);
    endfunction

    function automatic logic [19:0] exp_entry(input int k, input int t);
        return {base_of(k) + 16'd5, 1'(t % 2), 1'((t / 2) % 2), 1'((t / 4) % 2),
                1'(t % 8 == 7)};
    endfunction

    task automatic drive_win(input logic [15:0] w00, input logic [15:0] w01,
                             input logic [15:0] w10, input logic [15:0] w11);
        @(negedge clk);
        ai.window[0][0] = w00;
        ai.window[0][1] = w01;
        ai.window[1][0] = w10;
        ai.window[1][1] = w11;
        ai.win_valid    = 1'b1;
    endtask

    // Window k: all elements equal base, except one (position k%4) at base+5.
    task automatic send(input int k);
        logic [15:0] v [4];
        for (int i = 0; i < 4; i++) v[i] = (i == k % 4) ? base_of(k) + 16'd5 : base_of(k);
        drive_win(v[0], v[1], v[2], v[3]);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ai.win_valid = 1'b0;
        end
    endtask

    task automatic chk_stream(input string tag, input int qoff, input int k0, input int t0,
                              input int n);
        for (int i = 0; i < n; i++)
            chk(tag, (qoff + i < q.size()) ? q[qoff + i] : 20'hxxxxx, exp_entry(k0 + i, t0 + i));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        ai.win_valid = 1'b0;
        ai.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        q.delete();
        fd_cnt = 0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; fd_cnt = 0;
        rst = 1'b1;
        ai.win_valid = 1'b0;
        ai.window    = '0;
        ai.out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", ai.out_valid, 0);
        chk("rst_out_last", ai.out_last, 0);
        chk("rst_almost_full", ai.almost_full, 0);
        chk("rst_overflow", ai.overflow, 0);
        chk("rst_frame_done", ai.frame_done, 0);
        chk("rst_data_known", $isunknown({ai.out_data, ai.out_chan, ai.out_col, ai.out_row}), 0);
        #5 rst = 1'b0;

        // Single window latency and signed max
        do_reset();
        ai.out_ready = 1'b1;
        drive_win(16'd3, 16'd9, -16'sd2, 16'd7);
        idle_n(1); chk("lat_e1_valid", ai.out_valid, 0);
        idle_n(1); chk("lat_e2_valid", ai.out_valid, 0);
        idle_n(1);
        chk("lat_valid", ai.out_valid, 1);
        chk("signed_max_a", ai.out_data, 16'd9);
        chk("tags_first", {ai.out_chan, ai.out_col, ai.out_row}, 0);
        drive_win(-16'sd5, -16'sd1, -16'sd8, -16'sd3);
        idle_n(3);
        chk("signed_max_neg", ai.out_data, 16'hFFFF);
        chk("tags_second", {ai.out_chan, ai.out_col, ai.out_row}, 3'b100);
        drive_win(16'hFFFF, 16'd1, 16'd2, 16'd3);
        idle_n(3);
        chk("signed_vs_ffff", ai.out_data, 16'd3);
        chk("unsigned_valid", bi.out_valid, 1);
        chk("unsigned_max", bi.out_data, 16'hFFFF);

        // Full frame of 8 plus one window of the next frame
        do_reset();
        ai.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) send(k);
        idle_n(6);
        chk("frame_count", q.size(), 9);
        chk_stream("frame_entry", 0, 0, 0, 9);
        chk("frame_done_pulses", fd_cnt, 1);

        // Backpressure: fill 4 entries, then drain
        do_reset();
        for (int k = 0; k < 4; k++) send(k);
        chk("bp_af_at_1", ai.almost_full, 0);
        chk("bp_valid_at_1", ai.out_valid, 1);
        idle_n(1);
        chk("bp_af_at_2", ai.almost_full, 1);
        idle_n(2);
        chk("bp_valid_full", ai.out_valid, 1);
        chk("bp_no_overflow", ai.overflow, 0);
        chk("bp_nothing_popped", q.size(), 0);
        #1 ai.out_ready = 1'b1;
        idle_n(6);
        chk("bp_drain_count", q.size(), 4);
        chk_stream("bp_entry", 0, 0, 0, 4);
        chk("bp_empty_valid", ai.out_valid, 0);
        chk("bp_empty_af", ai.almost_full, 0);

        // Overflow: 6 windows into 4 entries, then finish the frame
        do_reset();
        for (int k = 0; k < 6; k++) send(k);
        idle_n(3);
        chk("ovf_flag", ai.overflow, 1);
        chk("ovf_valid", ai.out_valid, 1);
        #1 ai.out_ready = 1'b1;
        idle_n(8);
        chk("ovf_kept", q.size(), 4);
        chk_stream("ovf_entry", 0, 0, 0, 4);
        for (int k = 6; k < 9; k++) send(k);
        idle_n(6);
        chk("ovf_total", q.size(), 7);
        chk_stream("ovf_tail", 4, 6, 6, 3);
        chk("ovf_frame_done", fd_cnt, 1);
        chk("ovf_sticky", ai.overflow, 1);

        // Write and pop on the same edge while full
        do_reset();
        for (int k = 0; k < 4; k++) send(k);
        idle_n(2);
        send(4);
        idle_n(2);
        #1 ai.out_ready = 1'b1;
        idle_n(1);
        chk("wp_no_overflow", ai.overflow, 0);
        chk("wp_af", ai.almost_full, 1);
        idle_n(8);
        chk("wp_count", q.size(), 5);
        chk_stream("wp_entry", 0, 0, 0, 5);
        chk("wp_no_overflow_end", ai.overflow, 0);

        // Asynchronous reset mid-frame
        do_reset();
        send(0); send(1); send(2);
        idle_n(2);
        chk("ar_pre_valid", ai.out_valid, 1);
        chk("ar_pre_af", ai.almost_full, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", ai.out_valid, 0);
        chk("ar_af", ai.almost_full, 0);
        chk("ar_last", ai.out_last, 0);
        chk("ar_overflow", ai.overflow, 0);
        chk("ar_frame_done", ai.frame_done, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        q.delete();
        ai.out_ready = 1'b1;
        send(5);
        idle_n(5);
        chk("ar_count", q.size(), 1);
        chk_stream("ar_entry", 0, 5, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
